mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with a
// valid/ready request channel, a valid/ready response channel and a
// programmable access latency (LATENCY cycles from accept to response).
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag latched addresses
// >= MEM_SIZE as errors (resp_err=1, resp_rdata=0, no write). Without it,
// resp_err is constant 0 and the address wraps on its low log2(MEM_SIZE) bits.
//
// PC_SIZE must be at least log2(MEM_SIZE).
module mem_responder #(
  parameter int WIDTH    = 32,
  parameter int MEM_SIZE = 1024,
  parameter int PC_SIZE  = 10,
  parameter int LATENCY  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [PC_SIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               resp_err
);

  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  localparam logic [PC_SIZE:0] MEM_LIMIT = MEM_SIZE[PC_SIZE:0];

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic [3:0] cnt;

  // Request fields captured on the accept edge; held for the whole transaction.
  logic               we_p0;
  logic [PC_SIZE-1:0] addr_p0;
  logic [WIDTH-1:0]   wdata_p0;

  logic [WIDTH-1:0] mem [MEM_SIZE];

  logic          accept;
  logic          access;
  logic          oob;
  logic          wr_en;
  logic [AW-1:0] idx;

  assign accept = req_valid && req_ready;
  // The access happens on the edge that ends the last WAIT cycle.
  assign access = (state == WAIT) && (cnt <= 4'd1);
  assign idx    = addr_p0[AW-1:0];
  // The comparison is always built; with bounds checking off it is masked to 0.
  assign oob    = BOUNDS_EN && ({1'b0, addr_p0} >= MEM_LIMIT);
  assign wr_en  = access && we_p0 && !oob;

  // Capture the request fields only on the accept edge so later changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Storage array: written only in the access cycle of an in-range store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata_p0;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= WAIT;
            cnt       <= LAT_INIT;
            req_ready <= 1'b0;
          end
        end
        WAIT: begin
          if (access) begin
            state      <= RESP;
            cnt        <= 4'd0;
            resp_valid <= 1'b1;
            resp_err   <= oob;
            if (oob) begin
              resp_rdata <= '0;
            end else if (we_p0) begin
              resp_rdata <= wdata_p0;
            end else begin
              resp_rdata <= mem[idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 1, 3, 4) with
// MEM_SIZE=256 and PC_SIZE=10, checked against a word-array reference model.
module tb_mem_responder;

  localparam int NI = 3;
  localparam int W  = 32;
  localparam int MS = 256;
  localparam int PC = 10;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [NI];
  logic          req_valid  [NI];
  logic          req_ready  [NI];
  logic          req_we     [NI];
  logic [PC-1:0] req_addr   [NI];
  logic [W-1:0]  req_wdata  [NI];
  logic          resp_valid [NI];
  logic          resp_ready [NI];
  logic [W-1:0]  resp_rdata [NI];
  logic          resp_err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .WIDTH   (W),
      .MEM_SIZE(MS),
      .PC_SIZE (PC),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: one word array per instance plus "has been written" flags.
  logic [W-1:0] mdl_mem [NI][MS];
  bit           mdl_set [NI][MS];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic void expect_resp(input int d, input bit we, input int addr,
                                      input logic [W-1:0] wd, output logic [W-1:0] er,
                                      output bit eerr, output bit known);
    if (BOUNDS && addr >= MS) begin
      er = '0; eerr = 1'b1; known = 1'b1;
    end else begin
      eerr = 1'b0;
      if (we) begin
        er = wd; known = 1'b1;
      end else begin
        er = mdl_mem[d][addr % MS]; known = mdl_set[d][addr % MS];
      end
    end
  endfunction

  function automatic void commit(input int d, input bit we, input int addr, input logic [W-1:0] wd);
    if (we && !(BOUNDS && addr >= MS)) begin
      mdl_mem[d][addr % MS] = wd;
      mdl_set[d][addr % MS] = 1'b1;
    end
  endfunction

  // Drives one full transaction on instance d; must be called at a negedge.
  task automatic run_txn(input int d, input bit we, input int addr, input logic [W-1:0] wd,
                         input int stall, output int waitc, output int lat, output bit rdy_low,
                         output logic [W-1:0] rdata, output logic err, output bit held);
    int n;
    waitc = 0; lat = -1; rdy_low = 1'b1; held = 1'b1; rdata = '0; err = 1'b0;
    while (req_ready[d] !== 1'b1 && waitc < 30) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 30) return;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = PC'(addr); req_wdata[d] = wd;
    resp_ready[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom);
    req_addr[d] = PC'($urandom); req_wdata[d] = $urandom;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 30) begin
      if (req_ready[d] !== 1'b0) rdy_low = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n++;
      req_addr[d] = PC'($urandom); req_wdata[d] = $urandom;
    end
    if (n >= 30) return;
    if (req_ready[d] !== 1'b0) rdy_low = 1'b0;
    lat = n; rdata = resp_rdata[d]; err = resp_err[d];
    for (int s = 0; s < stall; s++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = PC'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rdata || resp_err[d] !== err ||
          req_ready[d] !== 1'b0) held = 1'b0;
    end
    req_valid[d] = 1'b0; resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) held = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NI; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NI; d++) rst[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_req_ready[%0d] got=%b want=1", d, req_ready[d]); end
      checks++;
      if (resp_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_resp_valid[%0d] got=%b want=0", d, resp_valid[d]); end
      checks++;
      if (resp_rdata[d] !== '0) begin failures++; $display("FAIL reset_resp_rdata[%0d] got=%h want=0", d, resp_rdata[d]); end
      checks++;
      if (resp_err[d] !== 1'b0) begin failures++; $display("FAIL reset_resp_err[%0d] got=%b want=0", d, resp_err[d]); end
    end
  endtask

  task automatic test_store_load();
    int waitc, lat; bit rl, held; logic [W-1:0] rd; logic er;
    run_txn(0, 1'b1, 5, 32'hDEADBEEF, 0, waitc, lat, rl, rd, er, held);
    commit(0, 1'b1, 5, 32'hDEADBEEF);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL sl_store_latency got=%0d want=1", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_store_echo got=%h want=deadbeef", rd); end
    run_txn(0, 1'b0, 5, 32'h0, 0, waitc, lat, rl, rd, er, held);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL sl_load_latency got=%0d want=1", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_load_data got=%h want=deadbeef", rd); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL sl_load_err got=%b want=0", er); end
    checks++;
    if (waitc !== 0) begin failures++; $display("FAIL sl_next_accept_wait got=%0d want=0", waitc); end
  endtask

  task automatic test_latency();
    int waitc, lat; bit rl, held; logic [W-1:0] rd, v; logic er;
    v = $urandom;
    run_txn(1, 1'b1, 0, v, 0, waitc, lat, rl, rd, er, held);
    commit(1, 1'b1, 0, v);
    run_txn(1, 1'b0, 0, 32'h0, 0, waitc, lat, rl, rd, er, held);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL lat3_latency got=%0d want=3", lat); end
    checks++;
    if (rl !== 1'b1) begin failures++; $display("FAIL lat3_ready_low got=%b want=1", rl); end
    checks++;
    if (rd !== v) begin failures++; $display("FAIL lat3_load_data got=%h want=%h", rd, v); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL lat3_load_err got=%b want=0", er); end
  endtask

  task automatic test_backpressure();
    int waitc, lat; bit rl, held; logic [W-1:0] rd, v; logic er;
    v = $urandom;
    run_txn(1, 1'b1, 9, v, 4, waitc, lat, rl, rd, er, held);
    commit(1, 1'b1, 9, v);
    checks++;
    if (held !== 1'b1) begin failures++; $display("FAIL bp_store_hold got=%b want=1", held); end
    run_txn(1, 1'b0, 9, 32'h0, 4, waitc, lat, rl, rd, er, held);
    checks++;
    if (held !== 1'b1) begin failures++; $display("FAIL bp_load_hold got=%b want=1", held); end
    checks++;
    if (rd !== v) begin failures++; $display("FAIL bp_load_data got=%h want=%h", rd, v); end
    checks++;
    if (waitc !== 0) begin failures++; $display("FAIL bp_next_accept_wait got=%0d want=0", waitc); end
  endtask

  task automatic test_reset_mid();
    int waitc, lat; bit rl, held; logic [W-1:0] rd; logic er;
    logic [W-1:0] prev;
    prev = 32'h5555AAAA;
    run_txn(2, 1'b1, 7, prev, 0, waitc, lat, rl, rd, er, held);
    commit(2, 1'b1, 7, prev);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 10'd7; req_wdata[2] = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #2;
    rst[2] = 1'b0;
    #1;
    checks++;
    if (resp_valid[2] !== 1'b0) begin failures++; $display("FAIL rstmid_resp_valid got=%b want=0", resp_valid[2]); end
    checks++;
    if (req_ready[2] !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%b want=1", req_ready[2]); end
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    run_txn(2, 1'b0, 7, 32'h0, 0, waitc, lat, rl, rd, er, held);
    checks++;
    if (rd !== prev) begin failures++; $display("FAIL rstmid_no_write got=%h want=%h", rd, prev); end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL rstmid_latency got=%0d want=4", lat); end
  endtask

  task automatic test_bounds();
    int waitc, lat; bit rl, held; logic [W-1:0] rd, b, exp_rd; logic er, exp_er;
    b = $urandom;
    run_txn(0, 1'b1, 0, b, 0, waitc, lat, rl, rd, er, held);
    commit(0, 1'b1, 0, b);
    run_txn(0, 1'b1, 'h100, 32'hA5, 0, waitc, lat, rl, rd, er, held);
    commit(0, 1'b1, 'h100, 32'hA5);
    exp_er = BOUNDS;
    exp_rd = BOUNDS ? 32'h0 : 32'hA5;
    checks++;
    if (er !== exp_er) begin failures++; $display("FAIL bounds_store_err got=%b want=%b", er, exp_er); end
    checks++;
    if (rd !== exp_rd) begin failures++; $display("FAIL bounds_store_rdata got=%h want=%h", rd, exp_rd); end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL bounds_store_latency got=%0d want=1", lat); end
    run_txn(0, 1'b0, 0, 32'h0, 0, waitc, lat, rl, rd, er, held);
    exp_rd = BOUNDS ? b : 32'hA5;
    checks++;
    if (rd !== exp_rd) begin failures++; $display("FAIL bounds_load0 got=%h want=%h", rd, exp_rd); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL bounds_load0_err got=%b want=0", er); end
  endtask

  task automatic test_random();
    int waitc, lat, addr, stall; bit rl, held, we, known, eerr;
    logic [W-1:0] rd, wd, erd; logic er;
    for (int d = 0; d < NI; d++) begin
      for (int t = 0; t < 40; t++) begin
        we    = 1'($urandom);
        addr  = $urandom_range(0, 15) + (($urandom_range(0, 1) == 1) ? MS : 0);
        wd    = $urandom;
        stall = $urandom_range(0, 2);
        expect_resp(d, we, addr, wd, erd, eerr, known);
        run_txn(d, we, addr, wd, stall, waitc, lat, rl, rd, er, held);
        commit(d, we, addr, wd);
        checks++;
        if (lat !== lat_of(d)) begin failures++; $display("FAIL rnd_latency[%0d.%0d] got=%0d want=%0d", d, t, lat, lat_of(d)); end
        checks++;
        if (er !== eerr) begin failures++; $display("FAIL rnd_err[%0d.%0d] addr=%h got=%b want=%b", d, t, addr, er, eerr); end
        if (known) begin
          checks++;
          if (rd !== erd) begin failures++; $display("FAIL rnd_rdata[%0d.%0d] addr=%h we=%b got=%h want=%h", d, t, addr, we, rd, erd); end
        end
        checks++;
        if (waitc !== 0) begin failures++; $display("FAIL rnd_back_to_back[%0d.%0d] got=%0d want=0", d, t, waitc); end
        checks++;
        if (held !== 1'b1 || rl !== 1'b1) begin failures++; $display("FAIL rnd_handshake[%0d.%0d] held=%b ready_low=%b want=1,1", d, t, held, rl); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
